// File: rtl/traffic_light_ctrl.sv
// Two-approach traffic-light controller (A main, B side) with a pedestrian walk phase, timed on iCE ticks.
// Define TRAFFIC_FLASH_EN to add the iFlash input and the flashing A-yellow / B-red mode.
module traffic_light_ctrl #(
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 8,
    parameter int RED_TICKS    = 4,
    parameter int PED_TICKS    = 16,
    parameter int CNT_W        = 8
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iCE,
    input  logic       iSideCar,
    input  logic       iPedReq,
`ifdef TRAFFIC_FLASH_EN
    input  logic       iFlash,
`endif
    output logic [2:0] oLightA,
    output logic [2:0] oLightB,
    output logic       oWalk,
    output logic       oPedAck,
    output logic [2:0] oState
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        RED1     = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        RED2     = 3'd5,
        PED_WALK = 3'd6
    } stateT;

    localparam logic [CNT_W-1:0] greenLast  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] yellowLast = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] redLast    = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] pedLast    = CNT_W'(PED_TICKS - 1);

    stateT            state;
    stateT            nextState;
    logic [CNT_W-1:0] timer;
    logic             rPedPend;
    logic             rNextB;
    logic             enteringWalk;
    logic             greenHold;
`ifdef TRAFFIC_FLASH_EN
    logic             rFlashOn;
    logic             flashNext;
`endif

    // Lamp pattern {A, B} for a state; anything not green or yellow is all-red.
    function automatic logic [5:0] lampsFor(input stateT s);
        case (s)
            A_GREEN:  lampsFor = 6'b001_100;
            A_YELLOW: lampsFor = 6'b010_100;
            B_GREEN:  lampsFor = 6'b100_001;
            B_YELLOW: lampsFor = 6'b100_010;
            default:  lampsFor = 6'b100_100;
        endcase
    endfunction

    always_comb begin
        nextState = state;
        case (state)
            A_GREEN:  if (iCE && timer == greenLast && (iSideCar || rPedPend)) nextState = A_YELLOW;
            A_YELLOW: if (iCE && timer == yellowLast) nextState = RED1;
            RED1:     if (iCE && timer == redLast) nextState = rPedPend ? PED_WALK : B_GREEN;
            B_GREEN:  if (iCE && timer == greenLast) nextState = B_YELLOW;
            B_YELLOW: if (iCE && timer == yellowLast) nextState = RED2;
            RED2:     if (iCE && timer == redLast) nextState = rPedPend ? PED_WALK : A_GREEN;
            PED_WALK: if (iCE && timer == pedLast) nextState = rNextB ? B_GREEN : A_GREEN;
            default:  nextState = A_GREEN;
        endcase
    end

    assign enteringWalk = (nextState == PED_WALK) && (state != PED_WALK);
    // A green with no demand parks the timer at its last value so the first demanded tick exits.
    assign greenHold    = (state == A_GREEN) && (timer == greenLast);
`ifdef TRAFFIC_FLASH_EN
    assign flashNext    = rFlashOn ^ iCE;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= A_GREEN;
            timer    <= '0;
            rPedPend <= 1'b0;
            rNextB   <= 1'b0;
            oLightA  <= 3'b001;
            oLightB  <= 3'b100;
            oWalk    <= 1'b0;
            oPedAck  <= 1'b0;
            oState   <= 3'd0;
`ifdef TRAFFIC_FLASH_EN
            rFlashOn <= 1'b0;
        end else if (iFlash) begin
            state    <= A_GREEN;
            timer    <= '0;
            rPedPend <= 1'b0;
            rNextB   <= 1'b0;
            rFlashOn <= flashNext;
            oLightA  <= {1'b0, flashNext, 1'b0};
            oLightB  <= {flashNext, 2'b00};
            oWalk    <= 1'b0;
            oPedAck  <= 1'b0;
            oState   <= 3'd0;
`endif
        end else begin
`ifdef TRAFFIC_FLASH_EN
            rFlashOn <= 1'b0;
`endif
            state <= nextState;
            if (nextState != state)
                timer <= '0;
            else if (iCE && !greenHold)
                timer <= timer + 1'b1;
            // Serving a walk wins over a request arriving on the same clock.
            if (enteringWalk)
                rPedPend <= 1'b0;
            else if (iPedReq)
                rPedPend <= 1'b1;
            if (enteringWalk)
                rNextB <= (state == RED1);
            {oLightA, oLightB} <= lampsFor(nextState);
            oWalk   <= (nextState == PED_WALK);
            oPedAck <= enteringWalk;
            oState  <= nextState;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: stimulus queues expected phase changes, a monitor checks each one.
// Define TRAFFIC_FLASH_EN to also exercise the flashing mode.
module tb_traffic_light_ctrl;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iCE = 1'b0;
    logic       iSideCar = 1'b0;
    logic       iPedReq = 1'b0;
`ifdef TRAFFIC_FLASH_EN
    logic       iFlash = 1'b0;
`endif
    logic [2:0] oLightA;
    logic [2:0] oLightB;
    logic       oWalk;
    logic       oPedAck;
    logic [2:0] oState;

    typedef struct {
        logic [9:0] outs;
        int         ticks;
        bit         checkTicks;
    } expT;

    expT        sbQ[$];
    int         total = 0;
    int         bad = 0;
    int         ackCount = 0;
    int         ackBase;
    bit         monOn = 1'b0;
    int         ceCnt = 0;

    // Hand-written lamp table per state code: {red, yellow, green}.
    logic [2:0] lampA [0:6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] lampB [0:6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

    traffic_light_ctrl #(
        .GREEN_TICKS (4),
        .YELLOW_TICKS(2),
        .RED_TICKS   (1),
        .PED_TICKS   (3),
        .CNT_W       (8)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iCE     (iCE),
        .iSideCar(iSideCar),
        .iPedReq (iPedReq),
`ifdef TRAFFIC_FLASH_EN
        .iFlash  (iFlash),
`endif
        .oLightA (oLightA),
        .oLightB (oLightB),
        .oWalk   (oWalk),
        .oPedAck (oPedAck),
        .oState  (oState)
    );

    always #5 iClk = ~iClk;

    initial begin
        forever begin
            @(negedge iClk);
            ceCnt = (ceCnt + 1) % 4;
            iCE = (ceCnt == 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic sideCar, input logic pedReq, input logic rst, input int clocks);
        iSideCar = sideCar;
        iPedReq  = pedReq;
        iRst     = rst;
        for (int i = 0; i < clocks; i++) begin
            @(negedge iClk);
            #1;
        end
    endtask

    task automatic pushRaw(input logic [9:0] outs, input int ticks, input bit checkTicks);
        expT e;
        e.outs = outs;
        e.ticks = ticks;
        e.checkTicks = checkTicks;
        sbQ.push_back(e);
    endtask

    task automatic pushExp(input int code, input int ticks);
        pushRaw({3'(code), lampA[code], lampB[code], code == 6}, ticks, 1'b1);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < budget) begin
            @(negedge iClk);
            #1;
            n++;
        end
        if (sbQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: %0d expected phase changes not seen, required 0 left", name, sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic skipCeClock();
        if (iCE) applyStimulus(iSideCar, iPedReq, iRst, 1);
    endtask

    // Monitor: every output change pops one expected step; also checks phase length and oPedAck placement.
    initial begin
        logic [9:0] prevOuts;
        logic [9:0] curOuts;
        int         ticks;
        bit         ceEdge;
        expT        e;
        wait (monOn);
        @(negedge iClk);
        prevOuts = {oState, oLightA, oLightB, oWalk};
        ticks = 0;
        forever begin
            @(posedge iClk);
            ceEdge = iCE;
            if (iRst) ticks = 0;
            else if (iCE) ticks++;
            @(negedge iClk);
            curOuts = {oState, oLightA, oLightB, oWalk};
            if (oPedAck) begin
                ackCount++;
                checkOutput("ackFirstWalkClock", 32'({oState == 3'd6, prevOuts[9:7] != 3'd6}), 32'd3);
            end
            if (curOuts !== prevOuts) begin
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedChange: got 0x%0h, expected no change from 0x%0h", curOuts, prevOuts);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("stateLamps", 32'(curOuts), 32'(e.outs));
                    if (e.checkTicks) begin
                        checkOutput("phaseTicks", ticks, e.ticks);
                        checkOutput("changeOnCE", 32'(ceEdge), 32'd1);
                    end
                end
                ticks = 0;
            end
            prevOuts = curOuts;
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge iClk);
        #1;
        checkOutput("resetState", 32'(oState), 32'd0);
        checkOutput("resetLightA", 32'(oLightA), 32'b001);
        checkOutput("resetLightB", 32'(oLightB), 32'b100);
        checkOutput("resetWalkAck", 32'({oWalk, oPedAck}), 32'd0);
        monOn = 1'b1;

        $display("[TB] idle A green for 40 ticks");
        applyStimulus(0, 0, 0, 160);
        checkOutput("idleState", 32'(oState), 32'd0);
        checkOutput("idleLamps", 32'({oLightA, oLightB}), 32'b001_100);

        $display("[TB] side-street car cycle");
        applyStimulus(0, 0, 1, 1);
        pushExp(1, 4); pushExp(2, 2); pushExp(3, 1);
        pushExp(4, 4); pushExp(5, 2); pushExp(0, 1);
        applyStimulus(1, 0, 0, 0);
        waitDrain("sideCarCycle", 200);
        applyStimulus(0, 0, 0, 0);
        checkOutput("sideCarAcks", ackCount, 0);

        $display("[TB] pedestrian pulse during A green");
        ackBase = ackCount;
        skipCeClock();
        pushExp(1, 4); pushExp(2, 2); pushExp(6, 1); pushExp(3, 3);
        pushExp(4, 4); pushExp(5, 2); pushExp(0, 1);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);
        waitDrain("pedAfterRed1", 300);
        checkOutput("pedPulseAcks", ackCount - ackBase, 1);

        $display("[TB] request on the walk-entry clock");
        ackBase = ackCount;
        skipCeClock();
        pushExp(1, 4); pushExp(2, 2); pushExp(6, 1); pushExp(3, 3);
        pushExp(4, 4); pushExp(5, 2); pushExp(6, 1); pushExp(0, 3);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);
        n = 0;
        while (!(oState == 3'd2 && iCE) && n < 200) begin
            @(negedge iClk);
            #1;
            n++;
        end
        checkOutput("reachRed1BeforeExit", 32'(n < 200), 32'd1);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 0, 0, 0);
        waitDrain("secondWalk", 300);
        checkOutput("doubleWalkAcks", ackCount - ackBase, 2);

        $display("[TB] reset during B yellow drops pending walk");
        ackBase = ackCount;
        pushExp(1, 4); pushExp(2, 2); pushExp(3, 1); pushExp(4, 4);
        applyStimulus(1, 0, 0, 0);
        waitDrain("toBYellow", 200);
        applyStimulus(0, 1, 0, 1);
        pushRaw({3'd0, 3'b001, 3'b100, 1'b0}, 0, 1'b0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("postResetState", 32'(oState), 32'd0);
        checkOutput("postResetLightA", 32'(oLightA), 32'b001);
        waitDrain("resetChange", 4);
        pushExp(1, 4); pushExp(2, 2); pushExp(3, 1);
        pushExp(4, 4); pushExp(5, 2); pushExp(0, 1);
        applyStimulus(1, 0, 0, 0);
        waitDrain("noWalkAfterReset", 200);
        applyStimulus(0, 0, 0, 0);
        checkOutput("resetDropAcks", ackCount - ackBase, 0);

`ifdef TRAFFIC_FLASH_EN
        $display("[TB] flash mode for 6 ticks");
        skipCeClock();
        pushRaw({3'd0, 3'b000, 3'b000, 1'b0}, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) pushRaw({3'd0, 3'b010, 3'b100, 1'b0}, 1, 1'b1);
            else            pushRaw({3'd0, 3'b000, 3'b000, 1'b0}, 1, 1'b1);
        end
        iFlash = 1'b1;
        waitDrain("flashToggles", 100);
        pushRaw({3'd0, 3'b001, 3'b100, 1'b0}, 0, 1'b0);
        pushExp(1, 4);
        iFlash = 1'b0;
        applyStimulus(1, 0, 0, 0);
        waitDrain("flashRelease", 100);
        applyStimulus(0, 0, 0, 0);
`endif

        applyStimulus(0, 0, 0, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
